// File: rtl/fifo_rd_ctrl_if.sv
// Downstream valid/ready stream carrying words out of the FIFO read controller.
// The master presents data_out/valid; the slave returns ready.
interface fifo_rd_ctrl_if #(
    parameter int DATA_W = 12
) ();
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;

    modport master (
        output data_out,
        output valid,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        output ready
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Pop-side controller for the 12-bit transaction FIFO: tracks occupancy,
// issues pops, and hides the 1-cycle read latency in a 2-entry skid buffer.
module fifo_rd_ctrl #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              pop,
    fifo_rd_ctrl_if.master    dn,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err
);

    logic [1:0]        buf_cnt;
    logic              pop_d1;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              deq;
    logic              full;
    logic              push_acc;
    logic [2:0]        used;
    logic [2:0]        used_after;

    assign dn.data_out = head_q;
    assign dn.valid    = (buf_cnt != 2'd0);

    assign deq        = dn.valid & dn.ready;
    assign used       = {1'b0, buf_cnt} + {2'b0, pop_d1};
    assign used_after = used - {2'b0, deq};

    // Pop only if the skid buffer can absorb the word after this cycle's deq.
    assign pop = reset & rd_en & (occupancy != '0) & (used_after <= 3'd1);

    assign full     = (occupancy == CNT_W'(DEPTH));
    assign push_acc = push & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy    <= '0;
            overflow_err <= 1'b0;
        end else begin
            unique case (1'b1)
                push_acc & ~pop: occupancy <= occupancy + CNT_W'(1);
                pop & ~push_acc: occupancy <= occupancy - CNT_W'(1);
                default: ;
            endcase
            if (push & full & ~pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Tail capture; with one entry and a coincident deq the new word
    // goes straight to the head slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_d1  <= 1'b0;
            buf_cnt <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            pop_d1 <= pop;
            unique case (1'b1)
                pop_d1 & ~deq: begin
                    if (buf_cnt == 2'd0) begin
                        head_q <= fifo_data;
                    end else begin
                        tail_q <= fifo_data;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                deq & ~pop_d1: begin
                    if (buf_cnt == 2'd2) begin
                        head_q <= tail_q;
                    end
                    buf_cnt <= buf_cnt - 2'd1;
                end
                pop_d1 & deq: begin
                    if (buf_cnt == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end else begin
                        head_q <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 8-deep FIFO
// providing registered read data one cycle after pop.
module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] wdata = '0;
    logic [11:0] fifo_data = '0;
    logic        pop;
    logic [3:0]  occupancy;
    logic        overflow_err;

    int vectors = 0;
    int miscompares = 0;

    fifo_rd_ctrl_if #(.DATA_W(12)) dn ();

    fifo_rd_ctrl #(.DATA_W(12), .DEPTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .rd_en        (rd_en),
        .fifo_data    (fifo_data),
        .pop          (pop),
        .dn           (dn),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    logic        do_pop = 1'b0;
    logic        do_push = 1'b0;
    logic [11:0] wd_l = '0;
    logic [11:0] mtmp;
    bit          mfull;
    logic [11:0] q[$];
    logic [11:0] got[$];
    int          pop_cnt = 0;

    // Mid-cycle sampling of strobes and deliveries.
    always @(negedge clk) begin
        do_pop  = pop;
        do_push = push;
        wd_l    = wdata;
        if (reset && dn.valid && dn.ready) got.push_back(dn.data_out);
        if (pop) pop_cnt++;
    end

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
        end else begin
            mfull = (q.size() >= 8);
            if (do_pop && q.size() > 0) begin
                mtmp = q.pop_front();
                fifo_data <= mtmp;
            end
            if (do_push && (!mfull || do_pop)) q.push_back(wd_l);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dn.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        vectors++; if (dn.valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", dn.valid); end
        vectors++; if (dn.data_out !== 12'h000) begin miscompares++; $display("FAIL rst_data got=%h exp=000", dn.data_out); end
        vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL rst_pop got=%b exp=0", pop); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", overflow_err); end
        reset = 1'b1;
        rd_en = 1'b1;
        dn.ready = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        push = 1'b1;
        wdata = 12'h123;
        #1;
        vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL lat_pop_c0 got=%b exp=0", pop); end
        tick();
        push = 1'b0;
        #1;
        vectors++; if (occupancy !== 4'd1) begin miscompares++; $display("FAIL lat_occ_c1 got=%0d exp=1", occupancy); end
        vectors++; if (pop !== 1'b1) begin miscompares++; $display("FAIL lat_pop_c1 got=%b exp=1", pop); end
        tick();
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL lat_occ_c2 got=%0d exp=0", occupancy); end
        vectors++; if (dn.valid !== 1'b0) begin miscompares++; $display("FAIL lat_valid_c2 got=%b exp=0", dn.valid); end
        tick();
        vectors++; if (dn.valid !== 1'b1) begin miscompares++; $display("FAIL lat_valid_c3 got=%b exp=1", dn.valid); end
        vectors++; if (dn.data_out !== 12'h123) begin miscompares++; $display("FAIL lat_data_c3 got=%h exp=123", dn.data_out); end
        tick();
        vectors++; if (dn.valid !== 1'b0) begin miscompares++; $display("FAIL lat_valid_c4 got=%b exp=0", dn.valid); end
        vectors++; if (dn.data_out !== 12'h123) begin miscompares++; $display("FAIL lat_hold_c4 got=%h exp=123", dn.data_out); end
    endtask

    task automatic test_streaming();
        logic [11:0] exp;
        dn.ready = 1'b1;
        rd_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            push = (c < 8);
            wdata = 12'(c + 1);
            #1;
            vectors++; if (occupancy > 4'd2) begin miscompares++; $display("FAIL stream_occ c=%0d got=%0d exp<=2", c, occupancy); end
            if (c >= 3 && c <= 10) begin
                exp = 12'(c - 2);
                vectors++; if (dn.valid !== 1'b1 || dn.data_out !== exp) begin miscompares++; $display("FAIL stream_data c=%0d got=%b/%h exp=1/%h", c, dn.valid, dn.data_out, exp); end
            end
            tick();
        end
        push = 1'b0;
        #1;
        vectors++; if (dn.valid !== 1'b0 || occupancy !== 4'd0) begin miscompares++; $display("FAIL stream_idle got=%b/%0d exp=0/0", dn.valid, occupancy); end
    endtask

    task automatic test_backpressure();
        int base;
        logic [11:0] exp;
        dn.ready = 1'b0;
        rd_en = 1'b1;
        base = pop_cnt;
        for (int c = 0; c < 10; c++) begin
            push = (c < 8);
            wdata = 12'(12'h101 + c);
            tick();
        end
        push = 1'b0;
        #1;
        vectors++; if (pop_cnt - base !== 2) begin miscompares++; $display("FAIL bp_pops got=%0d exp=2", pop_cnt - base); end
        vectors++; if (occupancy !== 4'd6) begin miscompares++; $display("FAIL bp_occ got=%0d exp=6", occupancy); end
        vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL bp_pop got=%b exp=0", pop); end
        for (int s = 0; s < 3; s++) begin
            vectors++; if (dn.valid !== 1'b1 || dn.data_out !== 12'h101) begin miscompares++; $display("FAIL bp_hold s=%0d got=%b/%h exp=1/101", s, dn.valid, dn.data_out); end
            tick();
        end
        dn.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp = 12'(12'h101 + k);
            vectors++; if (dn.valid !== 1'b1 || dn.data_out !== exp) begin miscompares++; $display("FAIL bp_drain k=%0d got=%b/%h exp=1/%h", k, dn.valid, dn.data_out, exp); end
            tick();
        end
        vectors++; if (dn.valid !== 1'b0 || occupancy !== 4'd0) begin miscompares++; $display("FAIL bp_idle got=%b/%0d exp=0/0", dn.valid, occupancy); end
    endtask

    task automatic test_full();
        int gbase;
        int idle;
        logic [11:0] exp;
        rd_en = 1'b0;
        dn.ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            push = 1'b1;
            wdata = (c < 8) ? 12'(12'h201 + c) : 12'hFFF;
            tick();
        end
        push = 1'b0;
        #1;
        vectors++; if (occupancy !== 4'd8) begin miscompares++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
        vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL full_ovf got=%b exp=1", overflow_err); end
        vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL full_pop got=%b exp=0", pop); end
        gbase = got.size();
        rd_en = 1'b1;
        push = 1'b1;
        wdata = 12'h209;
        #1;
        vectors++; if (pop !== 1'b1) begin miscompares++; $display("FAIL full_pushpop got=%b exp=1", pop); end
        tick();
        push = 1'b0;
        #1;
        vectors++; if (occupancy !== 4'd8) begin miscompares++; $display("FAIL full_occ_pp got=%0d exp=8", occupancy); end
        idle = 0;
        for (int i = 0; i < 40 && idle < 3; i++) begin
            tick();
            idle = (occupancy == 4'd0 && !dn.valid) ? idle + 1 : 0;
        end
        vectors++; if (idle < 3) begin miscompares++; $display("FAIL full_drain_timeout got=%0d exp=3", idle); end
        vectors++; if (got.size() - gbase !== 9) begin miscompares++; $display("FAIL full_count got=%0d exp=9", got.size() - gbase); end
        for (int i = 0; i < 9 && gbase + i < got.size(); i++) begin
            exp = 12'(12'h201 + i);
            vectors++; if (got[gbase + i] !== exp) begin miscompares++; $display("FAIL full_order i=%0d got=%h exp=%h", i, got[gbase + i], exp); end
        end
        vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL full_sticky got=%b exp=1", overflow_err); end
    endtask

    task automatic test_rd_en_pause();
        int gbase;
        logic [11:0] exp;
        dn.ready = 1'b1;
        gbase = got.size();
        for (int c = 0; c < 30; c++) begin
            rd_en = ((c / 3) % 2 == 0);
            push = (c < 6);
            wdata = 12'(12'h301 + c);
            #1;
            if (!rd_en) begin
                vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL pause_pop c=%0d got=%b exp=0", c, pop); end
            end
            tick();
        end
        rd_en = 1'b1;
        push = 1'b0;
        repeat (4) tick();
        vectors++; if (got.size() - gbase !== 6) begin miscompares++; $display("FAIL pause_count got=%0d exp=6", got.size() - gbase); end
        for (int i = 0; i < 6 && gbase + i < got.size(); i++) begin
            exp = 12'(12'h301 + i);
            vectors++; if (got[gbase + i] !== exp) begin miscompares++; $display("FAIL pause_order i=%0d got=%h exp=%h", i, got[gbase + i], exp); end
        end
    endtask

    task automatic test_reset_midstream();
        int gbase;
        rd_en = 1'b1;
        dn.ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            push = (c < 4);
            wdata = 12'(12'h401 + c);
            tick();
        end
        push = 1'b0;
        #1;
        vectors++; if (dn.valid !== 1'b1 || occupancy !== 4'd2) begin miscompares++; $display("FAIL mid_pre got=%b/%0d exp=1/2", dn.valid, occupancy); end
        reset = 1'b0;
        #1;
        vectors++; if (occupancy !== 4'd0) begin miscompares++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
        vectors++; if (dn.valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%b exp=0", dn.valid); end
        vectors++; if (dn.data_out !== 12'h000) begin miscompares++; $display("FAIL mid_data got=%h exp=000", dn.data_out); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL mid_ovf got=%b exp=0", overflow_err); end
        vectors++; if (pop !== 1'b0) begin miscompares++; $display("FAIL mid_pop got=%b exp=0", pop); end
        tick();
        reset = 1'b1;
        dn.ready = 1'b1;
        gbase = got.size();
        push = 1'b1;
        wdata = 12'h0A1;
        tick();
        push = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dn.valid) break;
            tick();
        end
        vectors++; if (dn.valid !== 1'b1 || dn.data_out !== 12'h0A1) begin miscompares++; $display("FAIL mid_first got=%b/%h exp=1/0a1", dn.valid, dn.data_out); end
        repeat (3) tick();
        vectors++; if (got.size() - gbase !== 1) begin miscompares++; $display("FAIL mid_count got=%0d exp=1", got.size() - gbase); end
        if (got.size() > gbase) begin
            vectors++; if (got[gbase] !== 12'h0A1) begin miscompares++; $display("FAIL mid_word got=%h exp=0a1", got[gbase]); end
        end
    endtask

    initial begin
        dn.ready = 1'b0;
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_full();
        test_rd_en_pause();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
